// File: rtl/gray_counter.sv
// Free-running Gray-code counter with a registered binary mirror, a registered
// terminal-count flag and a sticky single-bit-change self-check.
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             tc,
  output logic             err
);

  localparam logic [WIDTH-1:0] LAST_CODE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [WIDTH-1:0] p_q;
  logic             tc_q, tc_d;
  logic             err_q, err_d;
  logic             armed_q;
  logic [WIDTH-1:0] diff;
  logic             one_hot;

  // Gray is encoded from the next binary value so it is a direct register load.
  always_comb begin
    b_d     = b_q + ONE;
    g_d     = b_d ^ (b_d >> 1);
    tc_d    = (g_d == LAST_CODE);
    diff    = g_q ^ p_q;
    one_hot = (diff != '0) && ((diff & (diff - ONE)) == '0);
    err_d   = err_q | (armed_q & ~one_hot);
  end

  // p trails g by one edge; the first edge after reset has no valid history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_q     <= '0;
      g_q     <= '0;
      p_q     <= '0;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      b_q     <= b_d;
      g_q     <= g_d;
      p_q     <= g_q;
      tc_q    <= tc_d;
      err_q   <= err_d;
      armed_q <= 1'b1;
    end
  end

  assign gray = g_q;
  assign bin  = b_q;
  assign tc   = tc_q;
  assign err  = err_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: WIDTH=4 instance checked against a Gray
// table, WIDTH=6 instance checked over a full 64-code period.
module tb_gray_counter;

  logic       clk;
  logic       reset;
  logic [3:0] gray4, bin4;
  logic       tc4, err4;
  logic [5:0] gray6, bin6;
  logic       tc6, err6;

  int n_vec;
  int n_err;

  gray_counter #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .reset(reset),
    .gray (gray4),
    .bin  (bin4),
    .tc   (tc4),
    .err  (err4)
  );

  gray_counter #(.WIDTH(6)) dut6 (
    .clk  (clk),
    .reset(reset),
    .gray (gray6),
    .bin  (bin6),
    .tc   (tc6),
    .err  (err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] gray_tab [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    logic [3:0] prev4;
    logic [5:0] prev6;
    logic [5:0] bb;
    logic [5:0] exp6;
    int         tc6_count;
    bit         found;

    gray_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    n_vec = 0;
    n_err = 0;

    // Reset held from time zero; sample before the first rising edge.
    reset = 1'b0;
    #4;
    check("rst_gray4", 32'(gray4), 32'h0);
    check("rst_bin4",  32'(bin4),  32'h0);
    check("rst_tc4",   32'(tc4),   32'h0);
    check("rst_err4",  32'(err4),  32'h0);
    check("rst_gray6", 32'(gray6), 32'h0);
    check("rst_tc6",   32'(tc6),   32'h0);

    @(negedge clk);
    reset = 1'b1;

    // Two full periods minus two: sequence, wrap, tc and single-bit steps.
    prev4 = 4'b0000;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      check("seq_gray", 32'(gray4), 32'(gray_tab[e % 16]));
      check("seq_bin",  32'(bin4),  32'(e % 16));
      check("seq_tc",   32'(tc4),   32'((e % 16) == 15));
      check("seq_err",  32'(err4),  32'h0);
      check("seq_step", 32'($countones(gray4 ^ prev4)), 32'd1);
      prev4 = gray4;
    end

    // Advance to code 0110, then assert reset between edges.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (gray4 == 4'b0110) found = 1'b1;
    end
    check("find_0110", 32'(gray4), 32'h6);
    #2;
    reset = 1'b0;
    #1;
    check("async_gray", 32'(gray4), 32'h0);
    check("async_bin",  32'(bin4),  32'h0);
    check("async_tc",   32'(tc4),   32'h0);
    check("async_err",  32'(err4),  32'h0);
    check("async_g6",   32'(gray6), 32'h0);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("resume_gray", 32'(gray4), 32'h1);
    check("resume_bin",  32'(bin4),  32'h1);
    check("resume_g6",   32'(gray6), 32'h1);

    // WIDTH=6: walk the remainder of a full 64-code period.
    prev6     = gray6;
    tc6_count = 0;
    for (int e = 2; e <= 65; e++) begin
      @(posedge clk);
      #1;
      bb   = 6'(e % 64);
      exp6 = bb ^ (bb >> 1);
      check("w6_gray", 32'(gray6), 32'(exp6));
      check("w6_bin",  32'(bin6),  32'(bb));
      check("w6_tc",   32'(tc6),   32'(bb == 6'd63));
      check("w6_step", 32'($countones(gray6 ^ prev6)), 32'd1);
      if (tc6) tc6_count++;
      prev6 = gray6;
    end
    check("w6_tc_once",   32'(tc6_count), 32'd1);
    check("w6_err",       32'(err6),      32'h0);
    check("w4_err_final", 32'(err4),      32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
